// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues in-order word fetches under a two-slot credit
// limit, tags them with their address and buffers responses for the decoder.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] insn,
    output logic [31:0] pc,
    output logic        insn_valid,
    input  logic        insn_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    logic [31:0]       fetch_pc, fetch_pc_n;
    logic [1:0][31:0]  tag_q, tag_n;
    logic [1:0]        tag_cnt, tag_cnt_n;
    logic [1:0][31:0]  fifo_insn, fifo_insn_n;
    logic [1:0][31:0]  fifo_pc, fifo_pc_n;
    logic [1:0]        fifo_cnt, fifo_cnt_n;
    logic [1:0]        kill_cnt, kill_n;
    logic [2:0]        in_use;
    logic              grant, rsp_kill, rsp_take, push, pop;

    // Killed requests still occupy a credit until their response comes back.
    assign in_use   = {1'b0, tag_cnt} + {1'b0, kill_cnt} + {1'b0, fifo_cnt};
    assign imem_req = rst_n & ~redirect & (in_use < 3'd2);
    assign grant    = imem_req & imem_gnt;

    assign rsp_kill = imem_rvalid & (kill_cnt != 2'd0);
    assign rsp_take = imem_rvalid & (kill_cnt == 2'd0) & (tag_cnt != 2'd0);
    assign push     = rsp_take & ~redirect;

    assign insn_valid = (fifo_cnt != 2'd0);
    assign pop        = insn_valid & insn_ready;
    assign insn       = insn_valid ? fifo_insn[0] : NOP_INSN;
    assign pc         = insn_valid ? fifo_pc[0] : fetch_pc;
    assign imem_addr  = fetch_pc;

    always_comb begin
        tag_n       = tag_q;
        tag_cnt_n   = tag_cnt;
        fifo_insn_n = fifo_insn;
        fifo_pc_n   = fifo_pc;
        fifo_cnt_n  = fifo_cnt;
        kill_n      = kill_cnt - {1'b0, rsp_kill};
        fetch_pc_n  = fetch_pc;

        if (rsp_take) begin
            tag_n[0]  = tag_q[1];
            tag_cnt_n = tag_cnt - 2'd1;
        end
        if (grant) begin
            tag_n[tag_cnt_n[0]] = fetch_pc;
            tag_cnt_n           = tag_cnt_n + 2'd1;
            fetch_pc_n          = fetch_pc + 32'd4;
        end

        if (pop) begin
            fifo_insn_n[0] = fifo_insn[1];
            fifo_pc_n[0]   = fifo_pc[1];
            fifo_cnt_n     = fifo_cnt - 2'd1;
        end
        if (push) begin
            fifo_insn_n[fifo_cnt_n[0]] = imem_rdata;
            fifo_pc_n[fifo_cnt_n[0]]   = tag_q[0];
            fifo_cnt_n                 = fifo_cnt_n + 2'd1;
        end

        // Every live request becomes a kill, less the one whose response lands now.
        if (redirect) begin
            kill_n     = kill_n + tag_cnt - {1'b0, rsp_take};
            tag_cnt_n  = 2'd0;
            fifo_cnt_n = 2'd0;
            fetch_pc_n = redirect_pc & ~32'h3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            tag_q     <= '0;
            tag_cnt   <= 2'd0;
            fifo_insn <= '0;
            fifo_pc   <= '0;
            fifo_cnt  <= 2'd0;
            kill_cnt  <= 2'd0;
        end else begin
            fetch_pc  <= fetch_pc_n;
            tag_q     <= tag_n;
            tag_cnt   <= tag_cnt_n;
            fifo_insn <= fifo_insn_n;
            fifo_pc   <= fifo_pc_n;
            fifo_cnt  <= fifo_cnt_n;
            kill_cnt  <= kill_n;
        end
    end

endmodule
